// File: rtl/sprite_pkg.sv
// Shared types and helpers for the drum-sprite flash arbiter.
package sprite_pkg;

    localparam int N_SPRITES = 14;

    typedef logic [N_SPRITES-1:0] sprite_vec_t;
    typedef logic [3:0]           sprite_idx_t;

    // Result of a lowest-set-bit search; idx is only meaningful when found is set.
    typedef struct packed {
        sprite_idx_t idx;
        logic        found;
    } lowest_t;

    // One-hot vector for a sprite index; indices outside 0..N_SPRITES-1 give all-zero.
    function automatic sprite_vec_t onehot_of(input sprite_idx_t idx);
        sprite_vec_t v;
        v = '0;
        for (int i = 0; i < N_SPRITES; i++) begin
            if (sprite_idx_t'(i) == idx) begin
                v[i] = 1'b1;
            end
        end
        return v;
    endfunction

    // Lowest set bit of vec; scanning downwards lets the lowest index overwrite higher ones.
    function automatic lowest_t lowest_set(input sprite_vec_t vec);
        lowest_t r;
        r = '0;
        for (int i = N_SPRITES - 1; i >= 0; i--) begin
            if (vec[i]) begin
                r.idx   = sprite_idx_t'(i);
                r.found = 1'b1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/sprite_flash_timer.sv
// One per-sprite flash timer: a hit reloads the full frame count, frame ticks
// count it down to zero, and active mirrors "count is nonzero" as a register.
module sprite_flash_timer #(
    parameter int  FLASH_FRAMES = 8,
    localparam int TW           = $clog2(FLASH_FRAMES + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic          tick,
    output logic          active,
    output logic [TW-1:0] count
);

    logic [TW-1:0] count_reg;
    logic [TW-1:0] count_next;
    logic          active_reg;

    // Load beats tick so a hit on the last frame restarts cleanly; the count saturates at zero.
    always_comb begin
        count_next = count_reg;
        if (load) begin
            count_next = TW'(FLASH_FRAMES);
        end else if (tick && (count_reg != '0)) begin
            count_next = count_reg - TW'(1);
        end
    end

    // Count and active flag are registered together so active never glitches on a reload.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_reg  <= '0;
            active_reg <= 1'b0;
        end else begin
            count_reg  <= count_next;
            active_reg <= (count_next != '0);
        end
    end

    assign active = active_reg;
    assign count  = count_reg;

endmodule

// File: rtl/sprite_flash_arbiter.sv
// Per-pixel sprite arbiter: most recently hit sprite wins an overlap, otherwise
// the lowest-index covering sprite. Grant is registered and always one-hot or zero.
module sprite_flash_arbiter
    import sprite_pkg::*;
#(
    parameter int  FLASH_FRAMES = 8,
    localparam int TW           = $clog2(FLASH_FRAMES + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_SPRITES-1:0] hit_pulse,
    input  logic                 frame_tick,
    input  logic                 pixel_valid,
    input  logic [N_SPRITES-1:0] pixel_hits,
    output logic [N_SPRITES-1:0] active,
    output logic [N_SPRITES-1:0] grant,
    output logic [3:0]           last_idx,
    output logic                 last_valid
);

    logic [TW-1:0] timer_count [N_SPRITES];

    sprite_vec_t   cand;
    lowest_t       cand_low;
    lowest_t       hit_low;
    sprite_vec_t   grant_reg;
    sprite_vec_t   grant_next;
    sprite_idx_t   last_idx_reg;
    sprite_idx_t   last_idx_next;
    logic          last_valid_reg;
    logic          last_valid_next;

    genvar gi;
    generate
        for (gi = 0; gi < N_SPRITES; gi++) begin : g_timer
            sprite_flash_timer #(
                .FLASH_FRAMES (FLASH_FRAMES)
            ) u_timer (
                .clk    (clk),
                .rst_n  (rst_n),
                .load   (hit_pulse[gi]),
                .tick   (frame_tick),
                .active (active[gi]),
                .count  (timer_count[gi])
            );
        end
    endgenerate

    // Candidate resolution and recency tracking; arbitration sees active as already registered.
    always_comb begin
        cand     = pixel_valid ? (pixel_hits & active) : '0;
        cand_low = lowest_set(cand);
        hit_low  = lowest_set(hit_pulse);

        grant_next = '0;
        if (last_valid_reg && cand[last_idx_reg]) begin
            grant_next = onehot_of(last_idx_reg);
        end else if (cand_low.found) begin
            grant_next = onehot_of(cand_low.idx);
        end

        last_idx_next   = last_idx_reg;
        last_valid_next = last_valid_reg;
        if (hit_low.found) begin
            last_idx_next   = hit_low.idx;
            last_valid_next = 1'b1;
        end else if (last_valid_reg && frame_tick && (timer_count[last_idx_reg] == TW'(1))) begin
            // The recent sprite's timer hits zero on this edge, same edge its active drops.
            last_valid_next = 1'b0;
        end
    end

    // Output and recency registers; reset clears everything so no grant survives an abort.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            grant_reg      <= '0;
            last_idx_reg   <= '0;
            last_valid_reg <= 1'b0;
        end else begin
            grant_reg      <= grant_next;
            last_idx_reg   <= last_idx_next;
            last_valid_reg <= last_valid_next;
        end
    end

    assign grant      = grant_reg;
    assign last_idx   = last_idx_reg;
    assign last_valid = last_valid_reg;

endmodule

// File: tb/tb_sprite_flash_arbiter.sv
// Bench for sprite_flash_arbiter: vector table, directed multi-cycle sequences,
// and randomized traffic compared against a frame-count reference model.
module tb_sprite_flash_arbiter;

    localparam int NS = 14;
    localparam int FF = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NS-1:0] hit_pulse;
    logic          frame_tick;
    logic          pixel_valid;
    logic [NS-1:0] pixel_hits;
    logic [NS-1:0] active;
    logic [NS-1:0] grant;
    logic [3:0]    last_idx;
    logic          last_valid;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sprite_flash_arbiter #(
        .FLASH_FRAMES (FF)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .hit_pulse   (hit_pulse),
        .frame_tick  (frame_tick),
        .pixel_valid (pixel_valid),
        .pixel_hits  (pixel_hits),
        .active      (active),
        .grant       (grant),
        .last_idx    (last_idx),
        .last_valid  (last_valid)
    );

    // Reference model: remaining frames per sprite, the recent sprite, and the pending grant.
    int            m_frames [NS];
    logic [NS-1:0] m_act;
    logic [NS-1:0] m_gnt;
    int            m_lidx;
    logic          m_lval;

    function automatic int lowest_idx(input logic [NS-1:0] v);
        for (int i = 0; i < NS; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_update(input logic [NS-1:0] h, input logic t, input logic pv,
                                input logic [NS-1:0] ph, input logic rn);
        logic [NS-1:0] cand;
        logic [NS-1:0] g;
        if (!rn) begin
            for (int i = 0; i < NS; i++) m_frames[i] = 0;
            m_act  = '0;
            m_gnt  = '0;
            m_lidx = 0;
            m_lval = 1'b0;
        end else begin
            cand = pv ? (ph & m_act) : '0;
            if (cand == '0)
                g = '0;
            else if (m_lval && cand[m_lidx])
                g = NS'(1) << m_lidx;
            else
                g = NS'(1) << lowest_idx(cand);
            if (h != '0) begin
                m_lidx = lowest_idx(h);
                m_lval = 1'b1;
            end else if (m_lval && t && m_frames[m_lidx] == 1) begin
                m_lval = 1'b0;
            end
            for (int i = 0; i < NS; i++) begin
                if (h[i])
                    m_frames[i] = FF;
                else if (t && m_frames[i] > 0)
                    m_frames[i] = m_frames[i] - 1;
                m_act[i] = (m_frames[i] != 0);
            end
            m_gnt = g;
        end
    endtask

    task automatic chk(input string name, input logic [NS-1:0] got, input logic [NS-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_active"}, active, m_act);
        chk({tag, "_grant"}, grant, m_gnt);
        chk({tag, "_last_idx"}, NS'(last_idx), NS'(m_lidx));
        chk({tag, "_last_valid"}, NS'(last_valid), NS'(m_lval));
    endtask

    // One clock: apply inputs, advance the model on the same edge, settle, then release strobes.
    task automatic step(input logic [NS-1:0] h, input logic t, input logic pv,
                        input logic [NS-1:0] ph, input logic rn);
        hit_pulse   = h;
        frame_tick  = t;
        pixel_valid = pv;
        pixel_hits  = ph;
        rst_n       = rn;
        @(posedge clk);
        model_update(h, t, pv, ph, rn);
        #1;
        hit_pulse   = '0;
        frame_tick  = 1'b0;
        pixel_valid = 1'b0;
        pixel_hits  = '0;
        rst_n       = 1'b1;
    endtask

    typedef struct {
        logic [NS-1:0] hit;
        logic          tick;
        logic          pv;
        logic [NS-1:0] ph;
        logic          rn;
        logic [NS-1:0] e_act;
        logic [NS-1:0] e_gnt;
        logic [3:0]    e_lidx;
        logic          e_lval;
    } vec_t;

    vec_t tbl [14];

    initial begin
        hit_pulse   = '0;
        frame_tick  = 1'b0;
        pixel_valid = 1'b0;
        pixel_hits  = '0;
        rst_n       = 1'b0;

        //            hit       tk  pv  ph        rn   act       gnt       lidx  lval
        tbl[0]  = '{14'h3FFF, 0, 0, 14'h0000, 0, 14'h0000, 14'h0000, 4'd0, 0};
        tbl[1]  = '{14'h3FFF, 0, 0, 14'h0000, 0, 14'h0000, 14'h0000, 4'd0, 0};
        tbl[2]  = '{14'h3FFF, 0, 0, 14'h0000, 0, 14'h0000, 14'h0000, 4'd0, 0};
        tbl[3]  = '{14'h0000, 0, 0, 14'h0000, 1, 14'h0000, 14'h0000, 4'd0, 0};
        tbl[4]  = '{14'h0120, 0, 0, 14'h0000, 1, 14'h0120, 14'h0000, 4'd5, 1};
        tbl[5]  = '{14'h0000, 0, 1, 14'h0120, 1, 14'h0120, 14'h0020, 4'd5, 1};
        tbl[6]  = '{14'h0000, 0, 0, 14'h0120, 1, 14'h0120, 14'h0000, 4'd5, 1};
        tbl[7]  = '{14'h0000, 0, 1, 14'h0100, 1, 14'h0120, 14'h0100, 4'd5, 1};
        tbl[8]  = '{14'h0000, 0, 1, 14'h3FFF, 1, 14'h0120, 14'h0020, 4'd5, 1};
        tbl[9]  = '{14'h0200, 0, 1, 14'h0200, 1, 14'h0320, 14'h0000, 4'd9, 1};
        tbl[10] = '{14'h0000, 0, 1, 14'h0204, 1, 14'h0320, 14'h0200, 4'd9, 1};
        tbl[11] = '{14'h0000, 0, 1, 14'h0324, 1, 14'h0320, 14'h0200, 4'd9, 1};
        tbl[12] = '{14'h0000, 0, 1, 14'h0320, 0, 14'h0000, 14'h0000, 4'd0, 0};
        tbl[13] = '{14'h0000, 0, 1, 14'h3FFF, 1, 14'h0000, 14'h0000, 4'd0, 0};

        for (int v = 0; v < 14; v++) begin
            step(tbl[v].hit, tbl[v].tick, tbl[v].pv, tbl[v].ph, tbl[v].rn);
            $display("vec %0d: hit=%h pv=%0b ph=%h rn=%0b -> active=%h grant=%h last_idx=%0d last_valid=%0b",
                     v, tbl[v].hit, tbl[v].pv, tbl[v].ph, tbl[v].rn, active, grant, last_idx, last_valid);
            chk("vec_active", active, tbl[v].e_act);
            chk("vec_grant", grant, tbl[v].e_gnt);
            chk("vec_last_idx", NS'(last_idx), NS'(tbl[v].e_lidx));
            chk("vec_last_valid", NS'(last_valid), NS'(tbl[v].e_lval));
        end

        // Flash lifetime: sprite 4, frame tick every 100 clocks, pixel covered by sprite 4.
        step('0, 0, 0, '0, 0);
        step(14'h0010, 0, 1, 14'h0010, 1);
        chk("life_rise", active, 14'h0010);
        for (int k = 1; k <= FF; k++) begin
            for (int c = 0; c < 99; c++) begin
                step('0, 0, 1, 14'h0010, 1);
                check_model("life");
            end
            chk("life_grant_on", grant, 14'h0010);
            step('0, 1, 1, 14'h0010, 1);
            check_model("life_tick");
            if (k < FF) begin
                chk("life_hold", active, 14'h0010);
            end else begin
                chk("life_fall", active, 14'h0000);
                chk("life_last_valid", NS'(last_valid), NS'(1'b0));
            end
        end
        step('0, 0, 1, 14'h0010, 1);
        chk("life_grant_off", grant, 14'h0000);
        $display("seq lifetime done: active=%h grant=%h", active, grant);

        // Overlap recency: sprite 2 then sprite 9; later sprites 0 and 2 retriggered.
        step('0, 0, 0, '0, 0);
        step(14'h0004, 0, 0, '0, 1);
        step('0, 1, 0, '0, 1);
        step(14'h0200, 0, 0, '0, 1);
        step('0, 0, 1, 14'h0204, 1);
        chk("recent_wins", grant, 14'h0200);
        step('0, 1, 0, '0, 1);
        step(14'h0005, 0, 0, '0, 1);
        chk("recent_idx0", NS'(last_idx), NS'(0));
        step('0, 0, 1, 14'h0204, 1);
        chk("recent_absent_lowest", grant, 14'h0004);
        for (int k = 0; k < 7; k++) begin
            step('0, 1, 1, 14'h0204, 1);
            check_model("recent");
        end
        step('0, 0, 1, 14'h0204, 1);
        chk("recent_expired_active", active, 14'h0005);
        chk("recent_expired_grant", grant, 14'h0004);
        $display("seq recency done: active=%h grant=%h last_idx=%0d", active, grant, last_idx);

        // Load vs tick: timer 0 run down to 1, then hit and tick together, then full recount.
        step('0, 0, 0, '0, 0);
        step(14'h0001, 0, 0, '0, 1);
        for (int k = 0; k < FF - 1; k++) step('0, 1, 0, '0, 1);
        chk("lvt_at_one", active, 14'h0001);
        step(14'h0001, 1, 0, '0, 1);
        chk("lvt_reload_active", active, 14'h0001);
        chk("lvt_reload_valid", NS'(last_valid), NS'(1'b1));
        for (int k = 0; k < FF - 1; k++) begin
            step('0, 1, 0, '0, 1);
            check_model("lvt");
        end
        chk("lvt_full_count", active, 14'h0001);
        step('0, 1, 0, '0, 1);
        chk("lvt_final_fall", active, 14'h0000);
        $display("seq load-vs-tick done: active=%h last_valid=%0b", active, last_valid);

        // Randomized traffic against the reference model.
        step('0, 0, 0, '0, 0);
        for (int n = 0; n < 3000; n++) begin
            logic [NS-1:0] h;
            logic [NS-1:0] ph;
            logic          t;
            logic          pv;
            logic          rn;
            h  = ($urandom_range(0, 15) == 0) ? NS'($urandom) : '0;
            t  = ($urandom_range(0, 19) == 0);
            pv = ($urandom_range(0, 3) != 0);
            ph = NS'($urandom);
            rn = ($urandom_range(0, 499) != 0);
            step(h, t, pv, ph, rn);
            check_model("rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sprite_flash_arbiter.md
Name: sprite_flash_arbiter

Overview:
- Schedules which of the 14 drum sprites is drawn at each pixel.
- Each drum hit starts a per-sprite flash timer, counted in video frames.
- Per pixel, the block resolves overlaps among active sprites: the most recently hit sprite wins, otherwise the lowest index wins.
- It emits a registered one-hot grant that feeds the one-hot-to-index sprite image selector in the graphics path.

Parameters:
- N_SPRITES, 14, number of sprites; must match the selector width.
- FLASH_FRAMES, 8, frames a sprite stays active after a hit (range 1..255).
- TW, $clog2(FLASH_FRAMES+1), timer width (derived, not overridden).

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  synchronous active-low reset
- hit_pulse  in  N_SPRITES  one-cycle drum-hit strobes, one bit per sprite, any combination
- frame_tick  in  1  one-cycle pulse at start of vertical blanking
- pixel_valid  in  1  current pixel is in the active video area
- pixel_hits  in  N_SPRITES  geometric coverage of the current pixel by each sprite
- active  out  N_SPRITES  sprite's flash timer is nonzero
- grant  out  N_SPRITES  one-hot (or all-zero) winning sprite for the pixel, registered
- last_idx  out  4  index 0..13 of the most recently hit sprite
- last_valid  out  1  last_idx is meaningful

Behaviour:
Reset
- rst_n sampled low at a clk edge clears all timers, active, grant and last_idx to 0, and last_valid to 0.
- Reset mid-flash aborts all flashes immediately; no residual grant on the next cycle.

Timers (one per sprite)
- hit_pulse[i]=1 loads timer[i] to FLASH_FRAMES.
- frame_tick=1 with timer[i]>0 decrements timer[i] by 1. The timer saturates at 0 and never wraps.
- hit_pulse[i] and frame_tick in the same cycle: load wins, so the timer becomes FLASH_FRAMES.
- A retrigger while active reloads to full; no accumulation.
- active[i] = (timer[i] != 0), registered. It rises 1 cycle after the hit and falls 1 cycle after the frame_tick that takes the timer to 0.

Recency
- Any hit_pulse bit set: last_idx <= lowest set index; last_valid <= 1.
- last_valid clears when the timer for last_idx reaches 0, unless the same cycle carries a new hit.

Arbitration (combinational candidate, registered output)
- cand = pixel_hits & active, qualified by pixel_valid.
- cand == 0: grant <= 0.
- last_valid and cand[last_idx] set: grant <= one-hot(last_idx).
- Otherwise: grant <= one-hot of lowest set bit of cand.
- Latency is 1 clk from pixel_hits/pixel_valid to grant. grant is never multi-hot, so the downstream selector never hits its default case from overlap.
- The arbiter uses active as registered. A hit in cycle t affects grant from cycle t+2.

Decomposition:
- Shared package sprite_pkg holds:
  - N_SPRITES = 14
  - typedef sprite_vec_t (logic [N_SPRITES-1:0])
  - typedef sprite_idx_t (logic [3:0])
  - function onehot_of(idx)
  - function lowest_set(vec) returning idx and found flag.
- Sub-module sprite_flash_timer holds one timer with load/tick/active and is instantiated N_SPRITES times via generate.
- Arbitration and recency logic live in the top level.

Test Plan:
- Reset behaviour: hold rst_n=0 for 3 clks with hit_pulse=14'h3FFF -> active=0, grant=0, last_valid=0 throughout; release, no hits -> outputs stay 0.
- Flash lifetime: hit_pulse[4] at t0, then frame_tick every 100 clks.
  - active[4]=1 from t0+1.
  - active[4] falls exactly 1 clk after the 8th frame_tick.
  - pixel_hits=14'h0010 with pixel_valid=1 -> grant=14'h0010 while active, 0 after.
- Overlap recency: hit sprite 2, then sprite 9 later; pixel_hits=14'h0204 -> grant=14'h0200. After sprite 9 expires and sprite 2 is still active -> grant=14'h0004.
- Simultaneous hits: hit_pulse=14'h0120 in one cycle -> last_idx=5; overlap pixel_hits=14'h0120 -> grant=14'h0020.
- Load vs tick: timer[0] at 1, hit_pulse[0] and frame_tick in the same cycle -> timer=8 and active[0] stays 1 with no glitch. Retrigger mid-flash restarts the full 8-frame count.
- Qualification: pixel_valid=0 with active sprites covering the pixel -> grant=0. Reset asserted mid-flash -> grant=0 on the next clk.
